// File: rtl/msk_aes_pkg.sv
// ---------------------------------------------------------------------------
// msk_aes_pkg
// Shared constants and helpers for the masked AES datapath.
//   AES_BLK_BITS   : bits per AES block (128)
//   BYTE_BITS      : bits per byte (8)
//   CT_FIFO_DEPTH  : number of ciphertext buffer slots in the output stage (2)
//   sh_idx()       : flat index of share `share` of bit `bit_j` of byte `byte_i`
//                    in a d-share bus (shares of one bit are adjacent).
// ---------------------------------------------------------------------------
package msk_aes_pkg;

    localparam int AES_BLK_BITS  = 128;
    localparam int BYTE_BITS     = 8;
    localparam int CT_FIFO_DEPTH = 2;

    // Share s of bit j of byte i sits at 8*d*i + d*j + s.
    function automatic int sh_idx(input int byte_i, input int bit_j,
                                  input int share, input int n_shares);
        return n_shares * (BYTE_BITS * byte_i + bit_j) + share;
    endfunction

endpackage

// File: rtl/msk_ct_slot.sv
// ---------------------------------------------------------------------------
// msk_ct_slot
// One shared-ciphertext storage slot.
//   clk, rst_n : clock, asynchronous active-low reset (contents zeroed)
//   load       : capture din on the next rising edge (wins over clear)
//   clear      : zero the slot on the next rising edge
//   din        : shared ciphertext to store, W bits
//   q          : current slot contents, W bits
// ---------------------------------------------------------------------------
module msk_ct_slot #(
    parameter int W = 256
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic [W-1:0] q
);

    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples its inputs as they were before the edge.
    // NOTE: storage is reset on purpose here -- a stale share must never
    // survive a reset and leak out on the output bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (clear) begin
            q <= '0;
        end
    end

endmodule

// File: rtl/msk_aes_ct_out_fifo.sv
// ---------------------------------------------------------------------------
// msk_aes_ct_out_fifo
// Two-slot output buffer behind the masked AES state datapath. Captures the
// shared ciphertext at end of encryption and hands it to the consumer over
// valid/ready. Each slot is zeroed as soon as it is read. Shares are never
// combined in the production build.
//
// Parameters
//   d      : number of shares (>= 2)
//   DEPTH  : buffer slots, must be 2
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_valid    : core offers sh_ct_in this cycle
//   in_ready    : a slot is free (registered)
//   sh_ct_in    : shared ciphertext, 128*d bits, byte i at [8*d*i +: 8*d]
//   out_valid   : head slot holds a ciphertext (registered)
//   out_ready   : consumer accepts the head
//   sh_ct_out   : head slot contents, all-zero when empty
//   count       : occupancy 0..2
//   ct_unmasked : (only with MSK_AES_CT_UNMASK_EN) XOR of the shares of the
//                 head, 128 bits, 0 when empty. Debug/test builds only.
// ---------------------------------------------------------------------------
module msk_aes_ct_out_fifo
    import msk_aes_pkg::*;
#(
    parameter int d     = 2,
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [AES_BLK_BITS*d-1:0] sh_ct_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [AES_BLK_BITS*d-1:0] sh_ct_out,
    output logic [1:0]                count
`ifdef MSK_AES_CT_UNMASK_EN
    ,
    output logic [AES_BLK_BITS-1:0]   ct_unmasked
`endif
);

    localparam int         W          = AES_BLK_BITS * d;
    localparam logic [1:0] FULL_COUNT = 2'(CT_FIFO_DEPTH);

    if (DEPTH != CT_FIFO_DEPTH) begin : g_bad_depth
        $error("msk_aes_ct_out_fifo: DEPTH must be 2");
    end
    if (d < 2) begin : g_bad_shares
        $error("msk_aes_ct_out_fifo: d must be at least 2");
    end

    logic                     wr_ptr;
    logic                     rd_ptr;
    logic [1:0]               count_q;
    logic [1:0]               count_nxt;
    logic                     out_valid_q;
    logic                     in_ready_q;
    logic                     push;
    logic                     pop;
    logic [CT_FIFO_DEPTH-1:0] slot_load;
    logic [CT_FIFO_DEPTH-1:0] slot_clear;
    logic [W-1:0]             slot_q [CT_FIFO_DEPTH];

    // in_ready is low when full, so an offer while full is never a push.
    assign push = in_valid & in_ready_q;
    assign pop  = out_valid_q & out_ready;

    // NOTE: the default assignment first keeps this block purely
    // combinational; without it some paths would hold a value and infer a latch.
    always_comb begin
        count_nxt = count_q;
        if (push && !pop) begin
            count_nxt = count_q + 2'd1;
        end else if (pop && !push) begin
            count_nxt = count_q - 2'd1;
        end
    end

    // Flags are registered from the next occupancy so both handshake outputs
    // come straight from flops with no input-to-output path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count_q     <= 2'd0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count_q     <= count_nxt;
            out_valid_q <= (count_nxt != 2'd0);
            in_ready_q  <= (count_nxt != FULL_COUNT);
        end
    end

    // A push and a pop in the same cycle always target different slots
    // (count=1 means wr_ptr != rd_ptr), so load/clear never collide.
    for (genvar g = 0; g < CT_FIFO_DEPTH; g++) begin : g_slot
        assign slot_load[g]  = push & (wr_ptr == 1'(g));
        assign slot_clear[g] = pop & (rd_ptr == 1'(g));

        msk_ct_slot #(
            .W (W)
        ) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (slot_load[g]),
            .clear (slot_clear[g]),
            .din   (sh_ct_in),
            .q     (slot_q[g])
        );
    end

    // Empty slots already hold zero; the gate makes the empty output explicit.
    assign sh_ct_out = out_valid_q ? slot_q[rd_ptr] : '0;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign count     = count_q;

`ifdef MSK_AES_CT_UNMASK_EN
    // Debug only: recombines the shares of the head slot.
    always_comb begin
        ct_unmasked = '0;
        for (int b = 0; b < AES_BLK_BITS / BYTE_BITS; b++) begin
            for (int j = 0; j < BYTE_BITS; j++) begin
                for (int s = 0; s < d; s++) begin
                    ct_unmasked[BYTE_BITS*b+j] = ct_unmasked[BYTE_BITS*b+j]
                                               ^ sh_ct_out[sh_idx(b, j, s, d)];
                end
            end
        end
    end
`endif

    // The core controller must never offer a ciphertext while the buffer is full.
    a_no_drop: assert property (@(posedge clk) disable iff (!rst_n)
                                !(in_valid && !in_ready_q))
        else $error("msk_aes_ct_out_fifo: ciphertext offered while full and dropped");

endmodule

// File: tb/tb_msk_aes_ct_out_fifo.sv
// ---------------------------------------------------------------------------
// tb_msk_aes_ct_out_fifo
// Directed and random checks of the masked ciphertext output buffer.
// Three instances (d = 2, 3, 4) share the control inputs; the d=2 instance is
// the main target of the directed vectors. With MSK_AES_CT_UNMASK_EN defined
// the debug unmask port is also checked.
// ---------------------------------------------------------------------------
module tb_msk_aes_ct_out_fifo;

    localparam int MAXW = 512;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            out_ready;
    logic [MAXW-1:0] sh_in;

    logic            in_ready2, in_ready3, in_ready4;
    logic            out_valid2, out_valid3, out_valid4;
    logic [1:0]      count2, count3, count4;
    logic [255:0]    sh_out2;
    logic [383:0]    sh_out3;
    logic [511:0]    sh_out4;
`ifdef MSK_AES_CT_UNMASK_EN
    logic [127:0]    um2, um3, um4;
`endif

    int checks = 0;
    int errors = 0;

    msk_aes_ct_out_fifo #(.d(2), .DEPTH(2)) dut2 (
        .clk (clk), .rst_n (rst_n),
        .in_valid (in_valid), .in_ready (in_ready2), .sh_ct_in (sh_in[255:0]),
        .out_valid (out_valid2), .out_ready (out_ready), .sh_ct_out (sh_out2),
        .count (count2)
`ifdef MSK_AES_CT_UNMASK_EN
        , .ct_unmasked (um2)
`endif
    );

    msk_aes_ct_out_fifo #(.d(3), .DEPTH(2)) dut3 (
        .clk (clk), .rst_n (rst_n),
        .in_valid (in_valid), .in_ready (in_ready3), .sh_ct_in (sh_in[383:0]),
        .out_valid (out_valid3), .out_ready (out_ready), .sh_ct_out (sh_out3),
        .count (count3)
`ifdef MSK_AES_CT_UNMASK_EN
        , .ct_unmasked (um3)
`endif
    );

    msk_aes_ct_out_fifo #(.d(4), .DEPTH(2)) dut4 (
        .clk (clk), .rst_n (rst_n),
        .in_valid (in_valid), .in_ready (in_ready4), .sh_ct_in (sh_in),
        .out_valid (out_valid4), .out_ready (out_ready), .sh_ct_out (sh_out4),
        .count (count4)
`ifdef MSK_AES_CT_UNMASK_EN
        , .ct_unmasked (um4)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [MAXW-1:0] got,
                         input logic [MAXW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [MAXW-1:0] v);
        sh_in    = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // Interleave up to four 128-bit shares: bit k of share s -> nsh*k + s.
    function automatic logic [MAXW-1:0] pack(input int nsh, input logic [127:0] s0,
                                             input logic [127:0] s1, input logic [127:0] s2,
                                             input logic [127:0] s3);
        logic [MAXW-1:0] v;
        logic [127:0]    sh [4];
        sh[0] = s0; sh[1] = s1; sh[2] = s2; sh[3] = s3;
        v = '0;
        for (int k = 0; k < 128; k++)
            for (int s = 0; s < nsh; s++)
                v[nsh*k+s] = sh[s][k];
        return v;
    endfunction

    function automatic logic [127:0] unmask(input int nsh, input logic [MAXW-1:0] v);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 128; k++)
            for (int s = 0; s < nsh; s++)
                r[k] = r[k] ^ v[nsh*k+s];
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [MAXW-1:0] rnd_vec();
        return {rnd128(), rnd128(), rnd128(), rnd128()};
    endfunction

    logic [MAXW-1:0] ct1, ct2, ct3, v, hd;
    logic [127:0]    sh_a, sh_b, mask;
    logic [MAXW-1:0] q [$];
    int              h, n;
    logic            do_push, do_pop;
    localparam logic [127:0] FIPS_CT = 128'h3925841d02dc09fbdc118597196a0b32;

    initial begin
        clk       = 1'b0;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sh_in     = '0;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_count", count2, 0);
        check("rst_flags", {out_valid2, in_ready2}, 2'b01);
        check("rst_data", sh_out2, 0);
        tick();
        tick();
        rst_n = 1'b1;

        // 1. Reset mid-operation: fill, then drop rst_n between clock edges
        ct1 = rnd_vec();
        ct2 = rnd_vec();
        push(ct1);
        push(ct2);
        check("fill_count", count2, 2);
        rst_n = 1'b0;
        #1;
        check("async_rst_count", {count2, count3, count4}, 0);
        check("async_rst_flags", {out_valid2, in_ready2, out_valid4, in_ready4}, 4'b0101);
        check("async_rst_data", {sh_out2, sh_out4}, 0);
        tick();
        rst_n = 1'b1;

        // 2. Single push/pop latency with byte-pattern shares
        for (int i = 0; i < 16; i++) begin
            sh_a[8*i+:8] = 8'(i);
            sh_b[8*i+:8] = 8'(255 - i);
        end
        v = pack(2, sh_a, sh_b, '0, '0);
        push(v);
        check("lat_valid", out_valid2, 1);
        check("lat_data", sh_out2, v[255:0]);
        check("lat_unmask", unmask(2, {256'd0, sh_out2}), {16{8'hFF}});
`ifdef MSK_AES_CT_UNMASK_EN
        check("lat_um_port", um2, {16{8'hFF}});
`endif
        pop();
        check("pop_valid", {out_valid2, count2}, 3'b000);
        check("pop_data", sh_out2, 0);
        check("pop_slot_zero", dut2.slot_q[0], 0);

        // 3. Back-to-back pushes with out_ready=0, then an offer while full
        ct1 = rnd_vec();
        ct2 = rnd_vec();
        ct3 = rnd_vec();
        push(ct1);
        push(ct2);
        check("full_count", count2, 2);
        check("full_in_ready", in_ready2, 0);
        sh_in    = ct3;
        in_valid = in_ready2;   // a well-behaved core holds off while full
        tick();
        in_valid = 1'b0;
        check("full_hold_count", count2, 2);
        check("full_head_ct1", sh_out2, ct1[255:0]);
        pop();
        check("order_ct2", sh_out2, ct2[255:0]);
        check("order_after1", {count2, in_ready2}, 3'b011);
        pop();
        check("order_empty", {count2, out_valid2}, 3'b000);
        check("order_empty_data", sh_out2, 0);

        // 4. Simultaneous push and pop at count=1, six times (pointers wrap)
        v = rnd_vec();
        push(v);
        h = 1;
        for (int it = 0; it < 6; it++) begin
            v         = rnd_vec();
            sh_in     = v;
            in_valid  = 1'b1;
            out_ready = 1'b1;
            tick();
            in_valid  = 1'b0;
            out_ready = 1'b0;
            check("pp_count", {count2, out_valid2}, 3'b011);
            check("pp_head", sh_out2, v[255:0]);
            check("pp_old_zero", dut2.slot_q[h], 0);
            h = 1 - h;
        end
        pop();
        check("pp_drain", count2, 0);

        // 5. Random traffic against a scoreboard queue, all three share counts
        q.delete();
        for (int c = 0; c < 10000; c++) begin
            n  = q.size();
            hd = (n != 0) ? q[0] : '0;
            check("rnd_ctl2", {count2, out_valid2, in_ready2}, {2'(n), n != 0, n != 2});
            check("rnd_ctl34", {count3, out_valid3, in_ready3, count4, out_valid4, in_ready4},
                  {2'(n), n != 0, n != 2, 2'(n), n != 0, n != 2});
            check("rnd_head2", sh_out2, hd[255:0]);
            check("rnd_head3", sh_out3, hd[383:0]);
            check("rnd_head4", sh_out4, hd);
`ifdef MSK_AES_CT_UNMASK_EN
            check("rnd_um", {um2, um3, um4},
                  {unmask(2, hd[255:0]), unmask(3, hd[383:0]), unmask(4, hd)});
`endif
            sh_in     = rnd_vec();
            in_valid  = ($urandom_range(0, 1) == 1) && in_ready2;
            out_ready = ($urandom_range(0, 1) == 1);
            do_push   = in_valid;
            do_pop    = out_ready && (n != 0);
            tick();
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(sh_in);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        check("rnd_drain", {count2, count3, count4}, 0);

        // 6. FIPS-197 ciphertext split into randomly masked shares
`ifdef MSK_AES_CT_UNMASK_EN
        check("um_empty", um2, 0);
`endif
        mask = rnd128();
        v    = pack(2, mask, FIPS_CT ^ mask, '0, '0);
        push(v);
        check("fips_data", sh_out2, v[255:0]);
        check("fips_unmask", unmask(2, {256'd0, sh_out2}), FIPS_CT);
`ifdef MSK_AES_CT_UNMASK_EN
        check("fips_um_port", um2, FIPS_CT);
`endif
        pop();
        check("fips_pop", {count2, out_valid2}, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
